// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I subset datapath (ADD, XOR, SLL, ADDI, LW, SW, BNE).
// Drives mux selects, write enables and memory handshake; traps illegal encodings.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUCtrl,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        trap,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLL = 3'd3
    } alu_t;

    state_t      cur;
    state_t      nxt;
    logic        retire;
    logic [31:0] count;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            cur   <= FETCH;
            count <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                count <= count + 32'd1;
        end
    end

    always_comb begin
        nxt      = cur;
        retire   = 1'b0;
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd0;
        ALUCtrl  = ALU_ADD;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        trap     = 1'b0;

        case (cur)
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = DECODE;
                end
            end
            DECODE: begin
                // ALUOut captures PC-relative branch target while dispatch resolves
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
                nxt     = TRAP;
                case (opcode)
                    7'b0110011:
                        if (funct7 == 7'd0 && (funct3 == 3'b000 || funct3 == 3'b100 || funct3 == 3'b001))
                            nxt = EXEC_R;
                    7'b0010011:
                        if (funct3 == 3'b000)
                            nxt = EXEC_I;
                    7'b0000011, 7'b0100011:
                        if (funct3 == 3'b010)
                            nxt = MEM_ADDR;
                    7'b1100011:
                        if (funct3 == 3'b001)
                            nxt = BRANCH;
                    default: nxt = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd0;
                case (funct3)
                    3'b100:  ALUCtrl = ALU_XOR;
                    3'b001:  ALUCtrl = ALU_SLL;
                    default: ALUCtrl = ALU_ADD;
                endcase
                nxt = WB_ALU;
            end
            EXEC_I: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                nxt     = WB_ALU;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                nxt     = (opcode == 7'b0000011) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)
                    nxt = WB_MEM;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    nxt    = FETCH;
                    retire = 1'b1;
                end
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
                retire   = 1'b1;
            end
            WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                nxt      = FETCH;
                retire   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd0;
                ALUCtrl = ALU_SUB;
                PCWrite = !zero;
                PCSrc   = 1'b1;
                nxt     = FETCH;
                retire  = 1'b1;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: nxt = FETCH;
        endcase

        state   = cur;
        instret = count;

        // Reset is synchronous, so outputs are forced low combinationally for the reset cycle
        if (reset) begin
            mem_req  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            PCSrc    = 1'b0;
            ALUSrcA  = '0;
            ALUSrcB  = '0;
            ALUCtrl  = '0;
            RegWrite = 1'b0;
            MemToReg = 1'b0;
            trap     = 1'b0;
            state    = '0;
            instret  = '0;
        end
    end

endmodule
